// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage.
// Holds the RV32I opcode and funct constants, the control-field encodings
// (ALU operation, ALU operand sources, writeback source), the trap causes,
// and decoded_t: the complete decoded bundle that travels through the
// output and skid registers.
package decode_pkg;

  // Major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  // funct7 values recognised on the OP opcode.
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // SYSTEM funct3 values that are never CSR accesses.
  localparam logic [2:0] SYSTEM_FUNCT_PRIV = 3'b000;
  localparam logic [2:0] SYSTEM_FUNCT_RSVD = 3'b100;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // ALU operations share the RV32I funct3 encoding, so OP/OP_IMM pass
  // funct3 straight through; everything else uses ADD.
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SR  = 3'b101;

  localparam logic [1:0] ALUSRC1_RS1  = 2'd0;
  localparam logic [1:0] ALUSRC1_PC   = 2'd1;
  localparam logic [1:0] ALUSRC1_ZERO = 2'd2;
  localparam logic [1:0] ALUSRC2_RS2  = 2'd0;
  localparam logic [1:0] ALUSRC2_IMM  = 2'd1;
  localparam logic [1:0] ALUSRC2_FOUR = 2'd2;

  localparam logic [1:0] WBSRC_ALU = 2'd0;
  localparam logic [1:0] WBSRC_MEM = 2'd1;
  localparam logic [1:0] WBSRC_CSR = 2'd2;

  localparam logic [3:0] TRAP_CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] TRAP_CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] TRAP_CAUSE_ECALL_M    = 4'd11;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  alu_src1;
    logic [1:0]  alu_src2;
    logic [1:0]  wb_src;
    logic [2:0]  funct;
    logic [2:0]  alu_op;
    logic        alu_op_alt;
    logic        mul_div;
    logic [11:0] csr_num;
    logic        csr_read;
    logic        csr_write;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] trap_value;
  } decoded_t;

endpackage

// File: rtl/decode_if.sv
// Fetch -> decode -> execute handshake bundle.
//   i_Valid/o_Ready/i_InstructionWord/i_PC : fetch side (valid/ready)
//   o_Valid/i_Ready/o_PC/o_Decoded         : execute side (valid/ready)
// slave  : the decode stage itself
// master : the surrounding pipeline (fetch producer + execute consumer)
interface decode_if #(parameter int PC_WIDTH = 32);
  import decode_pkg::*;

  logic                i_Valid;
  logic                o_Ready;
  logic [31:0]         i_InstructionWord;
  logic [PC_WIDTH-1:0] i_PC;
  logic                o_Valid;
  logic                i_Ready;
  logic [PC_WIDTH-1:0] o_PC;
  decoded_t            o_Decoded;

  modport slave (
    input  i_Valid, i_InstructionWord, i_PC, i_Ready,
    output o_Ready, o_Valid, o_PC, o_Decoded
  );

  modport master (
    output i_Valid, i_InstructionWord, i_PC, i_Ready,
    input  o_Ready, o_Valid, o_PC, o_Decoded
  );
endinterface

// File: rtl/decode_logic.sv
// Purely combinational RV32I(+M, +Zicsr) decoder: instruction word -> decoded_t.
//   instr_i : 32-bit instruction word
//   dec_o   : decoded bundle, including trap flag/cause/value
// ENABLE_M     : OP funct7=0000001 decodes as MUL/DIV instead of trapping.
// ENABLE_ZICSR : CSR instructions are legal instead of trapping.
module decode_logic
  import decode_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b0,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;
  decoded_t    dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    dec        = '0;
    illegal    = 1'b0;
    dec.rd     = instr_i[11:7];
    dec.rs1    = instr_i[19:15];
    dec.rs2    = instr_i[24:20];
    dec.funct  = funct3;

    if (instr_i[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPCODE_OP_IMM: begin
          dec.reg_write  = 1'b1;
          dec.alu_src2   = ALUSRC2_IMM;
          dec.alu_op     = funct3;
          // Bit 30 only selects SRAI; on other OP_IMM ops it is immediate data.
          dec.alu_op_alt = (funct3 == ALUOP_SR) && instr_i[30];
          dec.imm        = imm_i;
        end
        OPCODE_OP: begin
          if (funct7 == FUNCT7_BASE) begin
            dec.reg_write = 1'b1;
            dec.alu_op    = funct3;
          end else if (funct7 == FUNCT7_ALT && (funct3 == ALUOP_ADD || funct3 == ALUOP_SR)) begin
            dec.reg_write  = 1'b1;
            dec.alu_op     = funct3;
            dec.alu_op_alt = 1'b1;
          end else if (funct7 == FUNCT7_MULDIV && ENABLE_M) begin
            dec.reg_write = 1'b1;
            dec.mul_div   = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        OPCODE_LOAD: begin
          dec.reg_write = 1'b1;
          dec.mem_read  = 1'b1;
          dec.alu_src2  = ALUSRC2_IMM;
          dec.wb_src    = WBSRC_MEM;
          dec.imm       = imm_i;
        end
        OPCODE_STORE: begin
          dec.mem_write = 1'b1;
          dec.alu_src2  = ALUSRC2_IMM;
          dec.imm       = imm_s;
        end
        OPCODE_BRANCH: begin
          dec.branch     = 1'b1;
          dec.alu_op_alt = 1'b1;   // compare by subtraction
          dec.imm        = imm_b;
        end
        OPCODE_JAL: begin
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_src1  = ALUSRC1_PC;
          dec.alu_src2  = ALUSRC2_FOUR;
          dec.imm       = imm_j;
        end
        OPCODE_JALR: begin
          dec.jump      = 1'b1;
          dec.jalr      = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_src1  = ALUSRC1_PC;
          dec.alu_src2  = ALUSRC2_FOUR;
          dec.imm       = imm_i;
        end
        OPCODE_LUI: begin
          dec.reg_write = 1'b1;
          dec.alu_src1  = ALUSRC1_ZERO;
          dec.alu_src2  = ALUSRC2_IMM;
          dec.imm       = imm_u;
        end
        OPCODE_AUIPC: begin
          dec.reg_write = 1'b1;
          dec.alu_src1  = ALUSRC1_PC;
          dec.alu_src2  = ALUSRC2_IMM;
          dec.imm       = imm_u;
        end
        OPCODE_MISC_MEM: begin
          // FENCE: no effect in this in-order pipeline, decodes as a no-op.
        end
        OPCODE_SYSTEM: begin
          if (funct3 == SYSTEM_FUNCT_PRIV) begin
            if (instr_i == INSTR_ECALL) begin
              dec.trap       = 1'b1;
              dec.trap_cause = TRAP_CAUSE_ECALL_M;
            end else if (instr_i == INSTR_EBREAK) begin
              dec.trap       = 1'b1;
              dec.trap_cause = TRAP_CAUSE_BREAKPOINT;
            end else begin
              illegal = 1'b1;
            end
          end else if (funct3 == SYSTEM_FUNCT_RSVD || !ENABLE_ZICSR) begin
            illegal = 1'b1;
          end else begin
            dec.csr_num = instr_i[31:20];
            dec.imm     = {27'b0, instr_i[19:15]};
            dec.wb_src  = WBSRC_CSR;
            if (funct3[1:0] == 2'b01) begin
              // CSRRW[I]: skip the read side-effect when rd is x0.
              dec.csr_read  = (instr_i[11:7] != 5'd0);
              dec.csr_write = 1'b1;
            end else begin
              // CSRRS/C[I]: a zero mask means no write side-effect.
              dec.csr_read  = 1'b1;
              dec.csr_write = (instr_i[19:15] != 5'd0);
            end
            dec.reg_write = dec.csr_read;
          end
        end
        default: illegal = 1'b1;
      endcase
    end

    if (illegal) begin
      dec.trap       = 1'b1;
      dec.trap_cause = TRAP_CAUSE_ILLEGAL;
      dec.trap_value = instr_i;
    end

    // A trapping instruction must not have any architectural side effect.
    if (dec.trap) begin
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.csr_read  = 1'b0;
      dec.csr_write = 1'b0;
      dec.mul_div   = 1'b0;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage with valid/ready on both sides and a 2-entry skid.
//   i_Clock, i_Reset (synchronous, active-high), i_Flush (drop everything)
//   bus : decode_if.slave -- fetch word/PC in, decoded bundle/PC out
// Decode happens before the registers, so the output and skid entries hold
// decoded_t. o_Ready comes straight from the skid-valid flop, so there is no
// combinational path from i_Ready to o_Ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter bit ENABLE_M     = 1'b0,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  input  logic     i_Flush,
  decode_if.slave  bus
);

  decoded_t            in_dec;
  logic                accept, out_free;

  logic                out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0] out_pc_q,    out_pc_d;
  decoded_t            out_dec_q,   out_dec_d;
  logic                skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0] skid_pc_q,    skid_pc_d;
  decoded_t            skid_dec_q,   skid_dec_d;

  decode_logic #(
    .ENABLE_M     (ENABLE_M),
    .ENABLE_ZICSR (ENABLE_ZICSR)
  ) u_decode_logic (
    .instr_i (bus.i_InstructionWord),
    .dec_o   (in_dec)
  );

  assign accept   = bus.i_Valid && !skid_valid_q;
  // Output register can take a new entry when empty or being drained this cycle.
  assign out_free = !out_valid_q || bus.i_Ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_dec_d    = out_dec_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_dec_d   = skid_dec_q;

    if (i_Flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; o_Ready was low, so nothing new arrives.
        out_valid_d  = 1'b1;
        out_pc_d     = skid_pc_q;
        out_dec_d    = skid_dec_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_pc_d  = bus.i_PC;
          out_dec_d = in_dec;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = bus.i_PC;
      skid_dec_d   = in_dec;
    end
  end

  always_ff @(posedge i_Clock) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples its _d value from before this edge.
    if (i_Reset) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_dec_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_dec_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_dec_q    <= out_dec_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_dec_q   <= skid_dec_d;
    end
  end

  assign bus.o_Ready   = !skid_valid_q;
  assign bus.o_Valid   = out_valid_q;
  assign bus.o_PC      = out_pc_q;
  assign bus.o_Decoded = out_dec_q;

endmodule
